// File: rtl/hsio_port.sv
// Multi-channel parallel I/O port: per-channel FWFT receive FIFO plus 4-phase req/ack on the peripheral side.
// Input ack appears SYNC_STAGES+1 edges after req; a full FIFO withholds ack. Optional interrupt when HSIO_IRQ_EN is defined.
module hsio_port #(
  parameter int NCH         = 2,
  parameter int DW          = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    cpu_inp_rd,
  output logic [NCH*DW-1:0] cpu_inpr,
  output logic [NCH-1:0]    cpu_fgi,
  input  logic [NCH-1:0]    cpu_out_wr,
  input  logic [DW-1:0]     cpu_outr,
  output logic [NCH-1:0]    cpu_fgo,
  input  logic [NCH-1:0]    ext_in_req,
  input  logic [NCH*DW-1:0] ext_in_data,
  output logic [NCH-1:0]    ext_in_ack,
  output logic [NCH-1:0]    ext_out_req,
  output logic [NCH*DW-1:0] ext_out_data,
  input  logic [NCH-1:0]    ext_out_ack,
`ifdef HSIO_IRQ_EN
  input  logic [2*NCH-1:0]  imsk,
  output logic              irq,
`endif
  output logic [NCH-1:0]    err,
  input  logic              err_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic       {I_IDLE, I_ACK} in_st_e;
  typedef enum logic [1:0] {O_IDLE, O_REQ, O_REL} out_st_e;

  logic [NCH-1:0] req_sync_q [SYNC_STAGES];
  logic [NCH-1:0] ack_sync_q [SYNC_STAGES];
  logic [NCH-1:0] req_s, ack_s;
  logic [NCH-1:0] err_q, err_d, err_set;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        req_sync_q[i] <= '0;
        ack_sync_q[i] <= '0;
      end
    end else begin
      req_sync_q[0] <= ext_in_req;
      ack_sync_q[0] <= ext_out_ack;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        req_sync_q[i] <= req_sync_q[i-1];
        ack_sync_q[i] <= ack_sync_q[i-1];
      end
    end
  end

  assign req_s = req_sync_q[SYNC_STAGES-1];
  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    in_st_e        ist_q;
    out_st_e       ost_q;
    logic          ack_q, fgo_q, oreq_q;
    logic [DW-1:0] odat_q;
    logic          push, pop, empty, full;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_FULL);
    assign push  = (ist_q == I_IDLE) && req_s[c] && !full;
    assign pop   = cpu_inp_rd[c] && !empty;

    always_comb begin
      cnt_d = cnt_q;
      if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
      else if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (push) begin
          mem_q[wptr_q] <= ext_in_data[c*DW +: DW];
          wptr_q        <= wptr_q + AW'(1);
        end
        if (pop) rptr_q <= rptr_q + AW'(1);
        cnt_q <= cnt_d;
      end
    end

    // Handshake state and all pin-facing outputs are registered here.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        ist_q  <= I_IDLE;
        ack_q  <= 1'b0;
        ost_q  <= O_IDLE;
        fgo_q  <= 1'b1;
        oreq_q <= 1'b0;
        odat_q <= '0;
      end else begin
        case (ist_q)
          I_IDLE: if (push) begin
            ack_q <= 1'b1;
            ist_q <= I_ACK;
          end
          I_ACK: if (!req_s[c]) begin
            ack_q <= 1'b0;
            ist_q <= I_IDLE;
          end
          default: ist_q <= I_IDLE;
        endcase
        case (ost_q)
          O_IDLE: if (cpu_out_wr[c]) begin
            odat_q <= cpu_outr;
            fgo_q  <= 1'b0;
            oreq_q <= 1'b1;
            ost_q  <= O_REQ;
          end
          O_REQ: if (ack_s[c]) begin
            oreq_q <= 1'b0;
            ost_q  <= O_REL;
          end
          O_REL: if (!ack_s[c]) begin
            fgo_q <= 1'b1;
            ost_q <= O_IDLE;
          end
          default: ost_q <= O_IDLE;
        endcase
      end
    end

    assign err_set[c]              = (cpu_inp_rd[c] && empty) || (cpu_out_wr[c] && !fgo_q);
    assign cpu_inpr[c*DW +: DW]     = empty ? '0 : mem_q[rptr_q];
    assign cpu_fgi[c]              = !empty;
    assign cpu_fgo[c]              = fgo_q;
    assign ext_in_ack[c]           = ack_q;
    assign ext_out_req[c]          = oreq_q;
    assign ext_out_data[c*DW +: DW] = odat_q;
  end

  // A new error in the same cycle as err_clr survives the clear.
  assign err_d = (err_q & ~{NCH{err_clr}}) | err_set;

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= err_d;
  end

  assign err = err_q;

`ifdef HSIO_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = |((cpu_fgi & imsk[NCH-1:0]) | (cpu_fgo & imsk[2*NCH-1:NCH]));

  always_ff @(posedge clk) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_hsio_port.sv
// Directed bench for hsio_port (NCH=2, DW=8, DEPTH=4, SYNC_STAGES=2); define HSIO_IRQ_EN to cover the interrupt.
module tb_hsio_port;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cpu_inp_rd;
  logic [15:0] cpu_inpr;
  logic [1:0]  cpu_fgi;
  logic [1:0]  cpu_out_wr;
  logic [7:0]  cpu_outr;
  logic [1:0]  cpu_fgo;
  logic [1:0]  ext_in_req;
  logic [15:0] ext_in_data;
  logic [1:0]  ext_in_ack;
  logic [1:0]  ext_out_req;
  logic [15:0] ext_out_data;
  logic [1:0]  ext_out_ack;
  logic [1:0]  err;
  logic        err_clr;
`ifdef HSIO_IRQ_EN
  logic [3:0]  imsk;
  logic        irq;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hsio_port #(.NCH(2), .DW(8), .DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_inp_rd(cpu_inp_rd), .cpu_inpr(cpu_inpr), .cpu_fgi(cpu_fgi),
    .cpu_out_wr(cpu_out_wr), .cpu_outr(cpu_outr), .cpu_fgo(cpu_fgo),
    .ext_in_req(ext_in_req), .ext_in_data(ext_in_data), .ext_in_ack(ext_in_ack),
    .ext_out_req(ext_out_req), .ext_out_data(ext_out_data), .ext_out_ack(ext_out_ack),
`ifdef HSIO_IRQ_EN
    .imsk(imsk), .irq(irq),
`endif
    .err(err), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_in_ack(input int ch, input logic val, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (ext_in_ack[ch] === val) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send(input int ch, input logic [7:0] d, output bit ok);
    bit ok_hi, ok_lo;
    ext_in_data[ch*8 +: 8] = d;
    ext_in_req[ch] = 1'b1;
    wait_in_ack(ch, 1'b1, 20, ok_hi);
    ext_in_req[ch] = 1'b0;
    wait_in_ack(ch, 1'b0, 20, ok_lo);
    ok = ok_hi && ok_lo;
  endtask

  task automatic pop(input int ch);
    cpu_inp_rd[ch] = 1'b1;
    tick();
    cpu_inp_rd[ch] = 1'b0;
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0; cpu_inp_rd = '0; cpu_out_wr = '0; cpu_outr = '0;
    ext_in_req = '0; ext_in_data = '0; ext_out_ack = '0; err_clr = 1'b0;
`ifdef HSIO_IRQ_EN
    imsk = '0;
`endif
    tick(3);
    chk("rst_fgo", 32'(cpu_fgo), 32'h3);
    chk("rst_fgi", 32'(cpu_fgi), 32'h0);
    chk("rst_in_ack", 32'(ext_in_ack), 32'h0);
    chk("rst_out_req", 32'(ext_out_req), 32'h0);
    chk("rst_out_data", 32'(ext_out_data), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_inpr", 32'(cpu_inpr), 32'h0);
`ifdef HSIO_IRQ_EN
    chk("rst_irq", 32'(irq), 32'h0);
`endif
    rst_n = 1'b1;
    tick();

    // Channel 0 input latency: ack/fgi on the third edge after req rises.
    ext_in_data[7:0] = 8'h41;
    ext_in_req[0] = 1'b1;
    tick(2);
    chk("ch0_ack_early", 32'(ext_in_ack[0]), 32'h0);
    chk("ch0_fgi_early", 32'(cpu_fgi[0]), 32'h0);
    tick();
    chk("ch0_ack", 32'(ext_in_ack[0]), 32'h1);
    chk("ch0_fgi", 32'(cpu_fgi[0]), 32'h1);
    chk("ch0_inpr", 32'(cpu_inpr[7:0]), 32'h41);
    ext_in_req[0] = 1'b0;
    tick(2);
    chk("ch0_ack_hold", 32'(ext_in_ack[0]), 32'h1);
    tick();
    chk("ch0_ack_fall", 32'(ext_in_ack[0]), 32'h0);
    pop(0);
    chk("ch0_fgi_pop", 32'(cpu_fgi[0]), 32'h0);
    chk("ch0_inpr_pop", 32'(cpu_inpr[7:0]), 32'h0);
    chk("ch0_err_pop", 32'(err), 32'h0);

    // Channel 1: fill to four, fifth is held off until a pop.
    for (int i = 1; i <= 4; i++) begin
      send(1, 8'(i), ok);
      chk($sformatf("ch1_send%0d", i), 32'(ok), 32'h1);
    end
    chk("ch1_fgi_full", 32'(cpu_fgi[1]), 32'h1);
    ext_in_data[15:8] = 8'h05;
    ext_in_req[1] = 1'b1;
    tick(8);
    chk("ch1_bp_ack", 32'(ext_in_ack[1]), 32'h0);
    chk("ch1_head1", 32'(cpu_inpr[15:8]), 32'h01);
    pop(1);
    wait_in_ack(1, 1'b1, 10, ok);
    chk("ch1_fifth_ack", 32'(ok), 32'h1);
    ext_in_req[1] = 1'b0;
    wait_in_ack(1, 1'b0, 10, ok);
    chk("ch1_fifth_rel", 32'(ok), 32'h1);
    for (int i = 2; i <= 5; i++) begin
      chk($sformatf("ch1_head%0d", i), 32'(cpu_inpr[15:8]), 32'(i));
      pop(1);
    end
    chk("ch1_empty", 32'(cpu_fgi[1]), 32'h0);
    chk("ch1_err", 32'(err), 32'h0);

    // Simultaneous push and pop at count 2.
    send(1, 8'h11, ok);
    chk("pp_send11", 32'(ok), 32'h1);
    send(1, 8'h22, ok);
    chk("pp_send22", 32'(ok), 32'h1);
    ext_in_data[15:8] = 8'h33;
    ext_in_req[1] = 1'b1;
    tick(2);
    cpu_inp_rd[1] = 1'b1;
    tick();
    cpu_inp_rd[1] = 1'b0;
    chk("pp_ack", 32'(ext_in_ack[1]), 32'h1);
    chk("pp_head22", 32'(cpu_inpr[15:8]), 32'h22);
    ext_in_req[1] = 1'b0;
    wait_in_ack(1, 1'b0, 10, ok);
    chk("pp_rel", 32'(ok), 32'h1);
    pop(1);
    chk("pp_head33", 32'(cpu_inpr[15:8]), 32'h33);
    chk("pp_fgi_cnt1", 32'(cpu_fgi[1]), 32'h1);
    pop(1);
    chk("pp_empty", 32'(cpu_fgi[1]), 32'h0);

    // Output on channel 1.
    cpu_outr = 8'h5A; cpu_out_wr = 2'b10;
    tick();
    cpu_out_wr = '0;
    chk("out_fgo", 32'(cpu_fgo), 32'h1);
    chk("out_req", 32'(ext_out_req), 32'h2);
    chk("out_data", 32'(ext_out_data[15:8]), 32'h5A);
    cpu_outr = 8'hFF; cpu_out_wr = 2'b10;
    tick();
    cpu_out_wr = '0;
    chk("out_busy_data", 32'(ext_out_data[15:8]), 32'h5A);
    chk("out_busy_err", 32'(err), 32'h2);
    ext_out_ack[1] = 1'b1;
    tick(2);
    chk("out_req_hold", 32'(ext_out_req[1]), 32'h1);
    tick();
    chk("out_req_fall", 32'(ext_out_req[1]), 32'h0);
    chk("out_fgo_rel", 32'(cpu_fgo[1]), 32'h0);
    ext_out_ack[1] = 1'b0;
    tick(2);
    chk("out_fgo_hold", 32'(cpu_fgo[1]), 32'h0);
    tick();
    chk("out_fgo_back", 32'(cpu_fgo[1]), 32'h1);
    chk("out_data_kept", 32'(ext_out_data[15:8]), 32'h5A);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr", 32'(err), 32'h0);

    // Both channels load the shared write data.
    cpu_outr = 8'h3C; cpu_out_wr = 2'b11;
    tick();
    cpu_out_wr = '0;
    chk("dual_data", 32'(ext_out_data), 32'h3C3C);
    chk("dual_req", 32'(ext_out_req), 32'h3);

    // Pop on empty, and error set beats clear.
    cpu_inp_rd[0] = 1'b1; err_clr = 1'b1;
    tick();
    cpu_inp_rd[0] = 1'b0; err_clr = 1'b0;
    chk("empty_pop_err", 32'(err), 32'h1);
    chk("empty_pop_fgi", 32'(cpu_fgi), 32'h0);
    chk("empty_pop_inpr", 32'(cpu_inpr), 32'h0);

    // Reset during O_REQ.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_req", 32'(ext_out_req), 32'h0);
    chk("mid_rst_fgo", 32'(cpu_fgo), 32'h3);
    chk("mid_rst_err", 32'(err), 32'h0);
    chk("mid_rst_data", 32'(ext_out_data), 32'h0);

`ifdef HSIO_IRQ_EN
    imsk = 4'b0001;
    tick();
    chk("irq_idle", 32'(irq), 32'h0);
    ext_in_data[7:0] = 8'h77;
    ext_in_req[0] = 1'b1;
    tick(3);
    chk("irq_fgi", 32'(cpu_fgi[0]), 32'h1);
    chk("irq_lag", 32'(irq), 32'h0);
    tick();
    chk("irq_set", 32'(irq), 32'h1);
    imsk = 4'b0000;
    tick();
    chk("irq_mask", 32'(irq), 32'h0);
    ext_in_req[0] = 1'b0;
    tick(4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
